// File: rtl/gpio_bank_if.sv
// gpio_bank_if: Risco_5 SoC bus interface for the GPIO bank.
interface gpio_bank_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output read, write, address, write_data, input read_data);
    modport slave  (input read, write, address, write_data, output read_data);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with atomic output ops, input synchroniser,
// edge detection with sticky pending bits and level irq. Optional per-pin debounce
// filter and DBNC register (address 10) are enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_BITS = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] gpios_in,
    output logic [WIDTH-1:0] gpios_out,
    output logic [WIDTH-1:0] direction,
    output logic             irq
);
    logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d, re_q, re_d, fe_q, fe_d;
    logic [WIDTH-1:0] ie_q, ie_d, pend_q, pend_d, p_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s, f, ev, wd;
    logic [3:0]       sel;
    logic [15:0]      wr;
    logic [31:0]      rd;
    logic             unused_bits;

    assign sel         = bus.address[5:2];
    assign wd          = bus.write_data[WIDTH-1:0];
    assign wr          = bus.write ? (16'd1 << sel) : 16'd0;
    assign s           = sync_q[SYNC_STAGES-1];
    assign ev          = (f & ~p_q & re_q) | (~f & p_q & fe_q);
    assign gpios_out   = out_q;
    assign direction   = dir_q;
    assign irq         = |(pend_q & ie_q);
    assign unused_bits = ^{bus.address, bus.write_data};

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] dbnc_q, dbnc_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0]         f_q;

    assign dbnc_d = wr[10] ? bus.write_data[DEBOUNCE_BITS-1:0] : dbnc_q;
    assign f      = (dbnc_q == '0) ? s : f_q;

    // Per-pin filter: f_q takes s once s has disagreed for DBNC consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            dbnc_q <= '0;
            f_q    <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            dbnc_q <= dbnc_d;
            for (int i = 0; i < WIDTH; i++) begin
                if (dbnc_q != '0 && s[i] != f_q[i]) begin
                    if (cnt_q[i] >= dbnc_q - 1'b1) begin
                        f_q[i]   <= s[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    f_q[i]   <= s[i];
                    cnt_q[i] <= '0;
                end
            end
        end
    end
`else
    assign f = s;
`endif

    // Next state of the software-visible registers; pending set beats W1C clear
    always_comb begin
        dir_d  = wr[0] ? wd : dir_q;
        out_d  = wr[1] ? wd : wr[3] ? (out_q | wd) : wr[4] ? (out_q & ~wd) : wr[5] ? (out_q ^ wd) : out_q;
        re_d   = wr[6] ? wd : re_q;
        fe_d   = wr[7] ? wd : fe_q;
        ie_d   = wr[8] ? wd : ie_q;
        pend_d = (wr[9] ? (pend_q & ~wd) : pend_q) | ev;
    end

    // Register file, synchroniser chain and previous-value flops
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= '0;
            out_q  <= '0;
            re_q   <= '0;
            fe_q   <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            p_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            re_q      <= re_d;
            fe_q      <= fe_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            p_q       <= f;
            sync_q[0] <= gpios_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Read mux from current state; write-only and unmapped addresses read 0
    always_comb begin
        rd = '0;
        case (sel)
            4'd0: rd[WIDTH-1:0] = dir_q;
            4'd1: rd[WIDTH-1:0] = out_q;
            4'd2: rd[WIDTH-1:0] = f;
            4'd6: rd[WIDTH-1:0] = re_q;
            4'd7: rd[WIDTH-1:0] = fe_q;
            4'd8: rd[WIDTH-1:0] = ie_q;
            4'd9: rd[WIDTH-1:0] = pend_q;
`ifdef GPIO_DEBOUNCE_EN
            4'd10: rd[DEBOUNCE_BITS-1:0] = dbnc_q;
`endif
            default: rd = '0;
        endcase
    end

    assign bus.read_data = bus.read ? rd : 32'd0;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: randomized self-checking bench for gpio_bank against a queue-based model.
module tb_gpio_bank;
    localparam int SS = 2;
    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] gpios_in = 8'h00, gpios_out, direction;
    logic       irq;
    int         checks = 0, errors = 0;
    logic [7:0] m_dir, m_out, m_re, m_fe, m_ie, m_pend;
    logic [7:0] hist[$];

    gpio_bank_if bus();
    gpio_bank dut (.clk(clk), .reset(reset), .bus(bus), .gpios_in(gpios_in),
                   .gpios_out(gpios_out), .direction(direction), .irq(irq));

    always #5 clk = ~clk;

    function automatic logic [31:0] mrd(int r);
        case (r)
            0: return {24'h0, m_dir};
            1: return {24'h0, m_out};
            2: return {24'h0, hist[SS-1]};
            6: return {24'h0, m_re};
            7: return {24'h0, m_fe};
            8: return {24'h0, m_ie};
            9: return {24'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge
    task automatic cyc();
        logic [7:0] s, p, ev, wd;
        s  = hist[SS-1];
        p  = hist[SS];
        ev = (s & ~p & m_re) | (~s & p & m_fe);
        wd = bus.write_data[7:0];
        if (reset) begin
            {m_dir, m_out, m_re, m_fe, m_ie, m_pend} = '0;
            hist = {};
            repeat (SS + 1) hist.push_back(8'h00);
        end else begin
            m_pend = ((bus.write && bus.address[5:2] == 4'd9) ? (m_pend & ~wd) : m_pend) | ev;
            if (bus.write)
                case (bus.address[5:2])
                    4'd0: m_dir = wd;
                    4'd1: m_out = wd;
                    4'd3: m_out = m_out | wd;
                    4'd4: m_out = m_out & ~wd;
                    4'd5: m_out = m_out ^ wd;
                    4'd6: m_re = wd;
                    4'd7: m_fe = wd;
                    4'd8: m_ie = wd;
                    default: ;
                endcase
            hist.push_front(gpios_in);
            void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic wr(int r, logic [31:0] d);
        bus.write = 1'b1;
        bus.address = 32'(r) << 2;
        bus.write_data = d;
        cyc();
        bus.write = 1'b0;
        bus.write_data = $urandom;
    endtask

    task automatic rdreg(int r, output logic [31:0] v);
        bus.read = 1'b1;
        bus.address = (32'(r) << 2) | {$urandom_range(0, 3) << 6};
        #1 v = bus.read_data;
        bus.read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if ({direction, gpios_out, irq} !== 17'h0) begin errors++; $display("FAIL reset_outs: got %h required 0", {direction, gpios_out, irq}); end
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata_idle: got %h required 0", bus.read_data); end
        wr(0, 32'hFF);
        wr(1, 32'hA5);
        checks++; if (direction !== 8'hFF || gpios_out !== 8'hA5) begin errors++; $display("FAIL pre_reset_regs: got %h %h required ff a5", direction, gpios_out); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if ({direction, gpios_out, irq} !== 17'h0) begin errors++; $display("FAIL reset_clears: got %h required 0", {direction, gpios_out, irq}); end
        rdreg(0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_read_dir: got %h required 0", v); end
        rdreg(1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_read_out: got %h required 0", v); end
    endtask

    task automatic test_atomic();
        logic [31:0] v;
        wr(1, 32'h0F);
        checks++; if (gpios_out !== 8'h0F) begin errors++; $display("FAIL atomic_out: got %h required 0f", gpios_out); end
        wr(3, 32'hFFFF_FF30);
        wr(3, 32'h30);
        checks++; if (gpios_out !== 8'h3F) begin errors++; $display("FAIL atomic_set: got %h required 3f", gpios_out); end
        rdreg(3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL atomic_set_reads0: got %h required 0", v); end
        wr(4, 32'h01);
        checks++; if (gpios_out !== 8'h3E) begin errors++; $display("FAIL atomic_clr: got %h required 3e", gpios_out); end
        wr(5, 32'hFF);
        checks++; if (gpios_out !== 8'hC1) begin errors++; $display("FAIL atomic_tgl: got %h required c1", gpios_out); end
    endtask

    task automatic test_sync_latency();
        logic [31:0] v;
        wr(6, 32'h04);
        wr(8, 32'h04);
        gpios_in = 8'h04;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            rdreg(2, v);
            checks++; if (v !== (k >= 2 ? 32'h04 : 32'h0)) begin errors++; $display("FAIL sync_in_k%0d: got %h required %h", k, v, k >= 2 ? 32'h04 : 32'h0); end
            checks++; if (irq !== (k >= 3)) begin errors++; $display("FAIL sync_irq_k%0d: got %b required %b", k, irq, k >= 3); end
        end
        rdreg(9, v);
        checks++; if (v !== 32'h04) begin errors++; $display("FAIL sync_pending: got %h required 04", v); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        gpios_in = 8'h00;
        repeat (4) cyc();
        gpios_in = 8'h04;
        cyc();
        cyc();
        wr(9, 32'h04);
        rdreg(9, v);
        checks++; if (v !== 32'h04 || irq !== 1'b1) begin errors++; $display("FAIL collision_set_wins: got %h irq %b required 04 irq 1", v, irq); end
        wr(9, 32'h04);
        rdreg(9, v);
        checks++; if (v !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %h irq %b required 0 irq 0", v, irq); end
    endtask

    task automatic test_fall_ie();
        logic [31:0] v;
        wr(8, 32'h0);
        wr(6, 32'h0);
        wr(7, 32'h80);
        gpios_in = 8'h84;
        repeat (4) cyc();
        gpios_in = 8'h04;
        repeat (3) cyc();
        rdreg(9, v);
        checks++; if (v !== 32'h80 || irq !== 1'b0) begin errors++; $display("FAIL fall_pending: got %h irq %b required 80 irq 0", v, irq); end
        wr(8, 32'h80);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ie_enable_irq: got %b required 1", irq); end
        wr(8, 32'h0);
        rdreg(9, v);
        checks++; if (irq !== 1'b0 || v !== 32'h80) begin errors++; $display("FAIL ie_clear_keeps_pending: got %h irq %b required 80 irq 0", v, irq); end
        wr(9, 32'hFF);
    endtask

    task automatic test_random();
        logic [31:0] v, e;
        int r;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) gpios_in = 8'($urandom);
            r = $urandom_range(0, 15);
`ifdef GPIO_DEBOUNCE_EN
            if (r == 10) r = 9;
`endif
            bus.write = ($urandom_range(0, 1) == 1);
            bus.write_data = (r == 9 || r == 4) ? $urandom & $urandom : $urandom;
            bus.address = 32'(r) << 2;
            bus.read = 1'b1;
            e = mrd(r);
            #1 v = bus.read_data;
            bus.read = 1'b0;
            checks++; if (v !== e) begin errors++; $display("FAIL rand_read r%0d n%0d: got %h required %h", r, n, v, e); end
            cyc();
            bus.write = 1'b0;
            checks++; if (gpios_out !== m_out || direction !== m_dir) begin errors++; $display("FAIL rand_outs n%0d: got %h %h required %h %h", n, gpios_out, direction, m_out, m_dir); end
            checks++; if (irq !== |(m_pend & m_ie)) begin errors++; $display("FAIL rand_irq n%0d: got %b required %b", n, irq, |(m_pend & m_ie)); end
        end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] v;
        reset = 1'b1;
        gpios_in = 8'h00;
        cyc();
        reset = 1'b0;
        wr(10, 32'd4);
        wr(6, 32'h01);
        rdreg(10, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL dbnc_reg: got %h required 4", v); end
        gpios_in = 8'h01;
        repeat (3) cyc();
        gpios_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            cyc();
            rdreg(2, v);
            checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL dbnc_glitch_k%0d: got %b required 0", k, v[0]); end
        end
        rdreg(9, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL dbnc_glitch_pending: got %h required 0", v); end
        gpios_in = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            rdreg(2, v);
            checks++; if (v[0] !== (k >= 6)) begin errors++; $display("FAIL dbnc_level_k%0d: got %b required %b", k, v[0], k >= 6); end
        end
        gpios_in = 8'h00;
    endtask
`else
    task automatic test_unmapped();
        logic [31:0] v;
        for (int r = 10; r < 16; r++) begin
            wr(r, 32'hFFFF_FFFF);
            rdreg(r, v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_r%0d: got %h required 0", r, v); end
        end
        checks++; if (gpios_out !== m_out || direction !== m_dir) begin errors++; $display("FAIL unmapped_side_effect: got %h %h required %h %h", gpios_out, direction, m_out, m_dir); end
    endtask
`endif

    initial begin
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = 32'h0;
        bus.write_data = 32'h0;
        hist = {};
        repeat (SS + 1) hist.push_back(8'h00);
        @(negedge clk);
        cyc();
        test_reset();
        test_atomic();
        test_sync_latency();
        test_collision();
        test_fall_ie();
        test_random();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`else
        test_unmapped();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
